// File: rtl/adder_pkg.sv
// adder_pkg: shared defaults and result record for the adder/subtractor datapath
package adder_pkg;
  localparam int DEF_WIDTH = 6;
  localparam int DEF_SPLIT = 3;
  typedef struct packed {
    logic [DEF_WIDTH-1:0] s;
    logic                 bout;
    logic                 zero;
    logic                 ovf;
  } sub_res_t;
endpackage

// File: rtl/sub_slice.sv
// sub_slice: N-bit ripple-borrow subtract slice, d = a - b - bin
module sub_slice #(
  parameter int N = 3
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] d,
  output logic         bout
);
  logic [N:0] br;
  // borrow ripples from bit 0 upward
  always_comb begin
    br[0] = bin;
    d = '0;
    for (int i = 0; i < N; i++) begin
      d[i] = a[i] ^ b[i] ^ br[i];
      br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
    end
  end
  assign bout = br[N];
endmodule

// File: rtl/sub_pipe.sv
// sub_pipe: two-stage pipelined subtractor with borrow/zero/overflow flags and valid/ready flow
module sub_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SPLIT = DEF_SPLIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);
  localparam int H = WIDTH - SPLIT;
  logic             s1_valid, s2_valid, b_mid, lo_b, hi_b, adv1, adv2;
  logic [SPLIT-1:0] d_lo, lo_d;
  logic [H-1:0]     x_hi, y_hi, d_hi;
  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;
  sub_slice #(.N(SPLIT)) u_lo (.a(X[SPLIT-1:0]), .b(Y[SPLIT-1:0]), .bin(1'b0), .d(lo_d), .bout(lo_b));
  sub_slice #(.N(H)) u_hi (.a(x_hi), .b(y_hi), .bin(b_mid), .d(d_hi), .bout(hi_b));
  // stage 1: resolve the low bits and hold the high operands until stage 2 frees up
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      d_lo     <= '0;
      b_mid    <= 1'b0;
      x_hi     <= '0;
      y_hi     <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        d_lo  <= lo_d;
        b_mid <= lo_b;
        x_hi  <= X[WIDTH-1:SPLIT];
        y_hi  <= Y[WIDTH-1:SPLIT];
      end
    end
  end
  // stage 2: finish the high bits and register the result; sign bits come from the high operands
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      S        <= '0;
      bout     <= 1'b0;
      zero     <= 1'b0;
      ovf      <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        S    <= {d_hi, d_lo};
        bout <= hi_b;
        zero <= ({d_hi, d_lo} == '0);
        ovf  <= (x_hi[H-1] != y_hi[H-1]) && (d_hi[H-1] != x_hi[H-1]);
      end
    end
  end
endmodule

// File: tb/tb_sub_pipe.sv
// tb_sub_pipe: scoreboard bench for sub_pipe
module tb_sub_pipe;
  import adder_pkg::*;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic [5:0] X = 0, Y = 0;
  logic in_ready, out_valid, bout, zero, ovf;
  logic [5:0] S;
  int n_vec = 0, n_err = 0, cyc = 0;
  sub_res_t exp_q[$];

  sub_pipe dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .X(X), .Y(Y),
                .out_valid(out_valid), .out_ready(out_ready), .S(S), .bout(bout), .zero(zero), .ovf(ovf));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic sub_res_t model(input logic [5:0] x, input logic [5:0] y);
    logic [6:0] t;
    sub_res_t r;
    t = {1'b0, x} - {1'b0, y};
    r.s = t[5:0];
    r.bout = t[6];
    r.zero = (t[5:0] == 0);
    r.ovf = (x[5] != y[5]) && (t[5] != x[5]);
    return r;
  endfunction

  function automatic sub_res_t mk(input logic [5:0] s, input logic b, input logic z, input logic o);
    sub_res_t r;
    r.s = s; r.bout = b; r.zero = z; r.ovf = o;
    return r;
  endfunction

  // monitor: every output transfer is checked against the head of the expected queue
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", {23'd0, S, bout, zero, ovf}, 32'hFFFF_FFFF);
      else chk("result", {23'd0, S, bout, zero, ovf}, {23'd0, exp_q.pop_front()});
    end
  end

  task automatic send(input logic [5:0] x, input logic [5:0] y, input sub_res_t e);
    int n = 0;
    in_valid = 1; X = x; Y = y;
    @(negedge clk);
    while (!in_ready && n < 50) begin n++; @(negedge clk); end
    if (!in_ready) chk("send_timeout", 0, 1);
    else exp_q.push_back(e);
    @(posedge clk); #1 in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin n++; @(posedge clk); end
    #1 chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    int t0;
    logic [5:0] rx, ry;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_outputs", {S, bout, zero, ovf}, 0);
    @(posedge clk); #1;
    // latency: result visible after the second edge counting the accepting one
    in_valid = 1; X = 20; Y = 7;
    @(negedge clk);
    chk("lat_accept", in_ready, 1);
    exp_q.push_back(mk(13, 0, 0, 0));
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    chk("lat_edge1", out_valid, 0);
    @(negedge clk);
    chk("lat_edge2", out_valid, 1);
    @(posedge clk); #1;
    send(5, 9, mk(60, 1, 0, 0));
    send(42, 42, mk(0, 0, 1, 0));
    send(32, 1, mk(31, 0, 0, 1));
    drain();
    // back-pressure: two accepted, third held until the consumer resumes
    fork
      begin
        send(20, 7, mk(13, 0, 0, 0));
        send(5, 9, mk(60, 1, 0, 0));
        send(1, 1, mk(0, 0, 1, 0));
      end
      begin
        out_ready = 0;
        repeat (3) @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_hold_s", S, 13);
        @(negedge clk);
        chk("bp_still_held", {in_ready, S}, {1'b0, 6'd13});
        @(posedge clk); #1 out_ready = 1;
      end
    join
    drain();
    // streaming: back-to-back random pairs at full rate
    t0 = cyc;
    for (int i = 0; i < 64; i++) begin
      rx = 6'($urandom_range(0, 63));
      ry = 6'($urandom_range(0, 63));
      send(rx, ry, model(rx, ry));
    end
    chk("stream_cycles", cyc - t0, 64);
    drain();
    // reset with two items in flight discards them
    out_ready = 0;
    send(10, 3, mk(7, 0, 0, 0));
    send(7, 2, mk(5, 0, 0, 0));
    rst = 1;
    exp_q.delete();
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1 out_ready = 1;
    send(3, 1, mk(2, 0, 0, 0));
    drain();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
